seg_scan_driver: RTL and testbench
==================================

# seg_scan_driver

- Time-multiplexed seven-segment driver for the mm:ss clock display.
- Takes the four BCD digits of the time and drives a four-digit common-anode display that shares one segment bus, decoding each digit to active-low segments.
- Sits at the display end of the clock datapath, as the on-chip alternative to per-digit external BCD decoders.
- Scan rate, inter-digit blanking, per-frame snapshotting of the digits, leading-zero suppression and invalid-code display are all fixed in this block.

## Interface
- SIZE, 4, width of each BCD digit input (only 4 is supported)
- REFRESH_DIV, 50000, clock cycles per digit slot; minimum 2
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- units_second  in  SIZE  BCD seconds units
- tens_second  in  SIZE  BCD seconds tens
- units_minute  in  SIZE  BCD minutes units
- tens_minute  in  SIZE  BCD minutes tens
- blank_leading  in  1  1 = suppress tens_minute when it is 0
- dp_en  in  1  1 = light the decimal point on units_minute (colon)
- digit_en_n  out  4  active-low anode selects; bit0 units_second … bit3 tens_minute
- seg_n  out  7  active-low segments {g,f,e,d,c,b,a}
- dp_n  out  1  active-low decimal point

## Operation
**Counters**
- Prescaler pre counts 0..REFRESH_DIV-1 and wraps to 0. Width is $clog2(REFRESH_DIV).
- Scan index idx (2 bits) advances 0→1→2→3→0 on the cycle pre == REFRESH_DIV-1.
- idx 0 = units_second, 1 = tens_second, 2 = units_minute, 3 = tens_minute.

**Snapshot**
- Loaded on every cycle with pre == 0 and idx == 0, including the first cycle after reset release.
- Captures all four digit inputs, blank_leading and dp_en.
- The rest of the frame displays only the snapshot; input changes mid-frame have no effect until the next frame.

**Slot timing**
- Blank sub-slot: pre == 0. All anodes off, all segments off (anti-ghosting).
- Active sub-slot: pre 1..REFRESH_DIV-1. Only anode idx is low.

**Decode (active-low)**
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Codes 10–15 (invalid BCD) display a dash: 0111111.

**Leading-zero suppression**
- Applies when idx == 3, the snapshot blank_leading is 1 and the snapshot tens_minute is 0.
- digit_en_n stays 1111 for the whole slot and seg_n = 1111111.

**Decimal point**
- dp_n = 0 only in the idx == 2 active sub-slot with snapshot dp_en = 1; 1 otherwise.

**Output registers**
- digit_en_n, seg_n and dp_n are registered.
- Output in cycle t+1 reflects pre/idx/snapshot in cycle t.

## Timing
**Reset**
- On reset: pre = 0, idx = 0, snapshot = 0.
- Outputs go to digit_en_n = 1111, seg_n = 1111111, dp_n = 1.
- Outputs change on the first edge with rst high; there is no asynchronous path.

**Latency and frame period**
- Output latency is 1 cycle from counter state.
- Frame = 4·REFRESH_DIV cycles.
- Each digit is lit for REFRESH_DIV-1 cycles per frame, preceded by 1 blank cycle.

**First frame after reset**
- The first cycle after release is blank (pre == 0 slot, snapshot loads).
- units_second appears from the second cycle after release.

**Boundary behaviour**
- Reset mid-slot: the next cycle is blank and the scan restarts at idx 0 with a fresh snapshot.
- Simultaneous input change and snapshot load: the new input value is captured.
- REFRESH_DIV = 2: one blank cycle then one active cycle per slot; must work unchanged.

## Test plan
All scenarios use REFRESH_DIV = 4.

1. **Reset**
   - Stimulus: rst high 3 cycles.
   - Required: digit_en_n = 1111, seg_n = 1111111, dp_n = 1 during reset and on the first cycle after release.
2. **Basic scan**
   - Stimulus: time 12:34, blank_leading = 0, dp_en = 1.
   - Required slot sequence:
     - 1110/0011001 for 3 cycles
     - blank, then 1101/0110000 ×3
     - blank, then 1011/0100100 ×3 with dp_n = 0
     - blank, then 0111/1111001 ×3
   - The sequence repeats every 16 cycles.
3. **Snapshot**
   - Stimulus: change the input from 12:34 to 56:78 during the idx 2 slot.
   - Required: the rest of that frame still shows 1 on idx 3; the next frame shows 8, 7, 6, 5.
4. **Leading zero**
   - Stimulus: time 05:00 with blank_leading = 1.
   - Required: the idx 3 slot holds digit_en_n = 1111 and seg_n = 1111111.
   - Stimulus: same time with blank_leading = 0.
   - Required: 0111/1000000.
5. **Invalid code**
   - Stimulus: tens_second = 4'hB.
   - Required: the idx 1 slot shows seg_n = 0111111 with anode 1101.
6. **Reset mid-operation**
   - Stimulus: assert rst for 1 cycle at pre = 2, idx = 2.
   - Required: the next cycle is fully blank; after release the scan restarts at units_second with a newly captured snapshot.

Source files
------------

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed driver for a four-digit common-anode
// seven-segment display showing mm:ss. Each frame latches a snapshot of the
// digits. Each digit slot opens with one blank cycle to prevent ghosting.
// All outputs are active-low and registered.
module seg_scan_driver #(
  parameter int SIZE        = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] units_second,
  input  logic [SIZE-1:0] tens_second,
  input  logic [SIZE-1:0] units_minute,
  input  logic [SIZE-1:0] tens_minute,
  input  logic            blank_leading,
  input  logic            dp_en,
  output logic [3:0]      digit_en_n,
  output logic [6:0]      seg_n,
  output logic            dp_n
);

  localparam int            PW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(REFRESH_DIV - 1);

  logic [PW-1:0]   pre;
  logic [1:0]      idx;
  logic [SIZE-1:0] snap_digit [4];
  logic            snap_blank_leading;
  logic            snap_dp_en;

  logic            frame_start;
  logic            leading_zero;
  logic [3:0]      nxt_digit_en_n;
  logic [6:0]      nxt_seg_n;
  logic            nxt_dp_n;

  // Active-low {g,f,e,d,c,b,a} pattern; non-BCD codes show a dash.
  function automatic logic [6:0] decode(input logic [3:0] bcd);
    case (bcd)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  assign frame_start  = (pre == '0) && (idx == 2'd0);
  assign leading_zero = (idx == 2'd3) && snap_blank_leading && (snap_digit[3] == '0);

  // Prescaler and scan index: one slot per REFRESH_DIV cycles, four slots per frame.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      pre <= '0;
      idx <= 2'd0;
    end else if (pre == PRE_MAX) begin
      pre <= '0;
      idx <= idx + 2'd1;
    end else begin
      pre <= pre + PW'(1);
    end
  end

  // Frame snapshot: latch digits and display options at the blank cycle of slot 0.
  always_ff @(posedge clk) begin
    // NOTE: the snapshot is four small registers, not a RAM, so it is reset
    // like any other flop and holds a defined value from the first frame.
    if (rst) begin
      for (int i = 0; i < 4; i++) snap_digit[i] <= '0;
      snap_blank_leading <= 1'b0;
      snap_dp_en         <= 1'b0;
    end else if (frame_start) begin
      snap_digit[0]      <= units_second;
      snap_digit[1]      <= tens_second;
      snap_digit[2]      <= units_minute;
      snap_digit[3]      <= tens_minute;
      snap_blank_leading <= blank_leading;
      snap_dp_en         <= dp_en;
    end
  end

  // Next output values from the current slot position and snapshot.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it
    // unassigned and no latch is inferred.
    nxt_digit_en_n = 4'b1111;
    nxt_seg_n      = 7'b1111111;
    nxt_dp_n       = 1'b1;
    if ((pre != '0) && !leading_zero) begin
      nxt_digit_en_n = ~(4'b0001 << idx);
      nxt_seg_n      = decode(snap_digit[idx]);
      nxt_dp_n       = !((idx == 2'd2) && snap_dp_en);
    end
  end

  // Output registers: glitch-free drive of the anodes, segments and point.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_en_n <= 4'b1111;
      seg_n      <= 7'b1111111;
      dp_n       <= 1'b1;
    end else begin
      digit_en_n <= nxt_digit_en_n;
      seg_n      <= nxt_seg_n;
      dp_n       <= nxt_dp_n;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Testbench for seg_scan_driver. Two instances run side by side: one with
// REFRESH_DIV = 4 and one with the minimum REFRESH_DIV = 2. Each is compared
// every cycle against a frame-position model. The model counts edges since
// reset, modulo the frame length.
module tb_seg_scan_driver;

  localparam int RD_A = 4;
  localparam int RD_B = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] us, ts, um, tm;
  logic       bl, dp;

  logic [3:0] en_a, en_b;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(.SIZE(4), .REFRESH_DIV(RD_A)) dut_a (
    .clk(clk), .rst(rst),
    .units_second(us), .tens_second(ts), .units_minute(um), .tens_minute(tm),
    .blank_leading(bl), .dp_en(dp),
    .digit_en_n(en_a), .seg_n(seg_a), .dp_n(dp_a)
  );

  seg_scan_driver #(.SIZE(4), .REFRESH_DIV(RD_B)) dut_b (
    .clk(clk), .rst(rst),
    .units_second(us), .tens_second(ts), .units_minute(um), .tens_minute(tm),
    .blank_leading(bl), .dp_en(dp),
    .digit_en_n(en_b), .seg_n(seg_b), .dp_n(dp_b)
  );

  // Reference glyphs, active-low {g,f,e,d,c,b,a}.
  logic [6:0] glyph [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
  };

  // Model state per instance: position in frame before the next edge,
  // plus the digits shown during the current frame.
  int         pos     [2];
  logic [3:0] snap    [2][4];
  logic       snap_bl [2];
  logic       snap_dp [2];
  logic [3:0] exp_en  [2];
  logic [6:0] exp_seg [2];
  logic       exp_dp  [2];

  task automatic model_edge(input int i, input int rd);
    int slot;
    int sub;
    exp_en[i]  = 4'b1111;
    exp_seg[i] = 7'b1111111;
    exp_dp[i]  = 1'b1;
    if (rst) begin
      pos[i] = 0;
      return;
    end
    if (pos[i] == 0) begin
      snap[i][0] = us; snap[i][1] = ts; snap[i][2] = um; snap[i][3] = tm;
      snap_bl[i] = bl;
      snap_dp[i] = dp;
    end
    slot = pos[i] / rd;
    sub  = pos[i] % rd;
    if (sub != 0 && !(slot == 3 && snap_bl[i] && snap[i][3] == 4'd0)) begin
      exp_en[i]  = 4'(~(4'b0001 << slot));
      exp_seg[i] = glyph[snap[i][slot]];
      exp_dp[i]  = !(slot == 2 && snap_dp[i]);
    end
    pos[i] = (pos[i] + 1) % (4 * rd);
  endtask

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] req);
    tests++;
    assert (obs === req) else begin
      fails++;
      $error("FAIL %s t=%0t observed en/seg/dp=%b required=%b", tag, $time, obs, req);
    end
  endtask

  // One clock: update model with the inputs seen at the edge, then compare.
  task automatic step();
    @(posedge clk);
    model_edge(0, RD_A);
    model_edge(1, RD_B);
    #1;
    check("rd4", {en_a, seg_a, dp_a}, {exp_en[0], exp_seg[0], exp_dp[0]});
    check("rd2", {en_b, seg_b, dp_b}, {exp_en[1], exp_seg[1], exp_dp[1]});
  endtask

  task automatic set_time(input logic [3:0] m1, input logic [3:0] m0,
                          input logic [3:0] s1, input logic [3:0] s0);
    tm = m1; um = m0; ts = s1; us = s0;
  endtask

  initial begin
    rst = 1'b1;
    set_time(4'd0, 4'd0, 4'd0, 4'd0);
    bl = 1'b0;
    dp = 1'b0;

    // Reset held three cycles: outputs blank throughout.
    repeat (3) step();
    check("reset_lit", {en_a, seg_a, dp_a}, 12'b1111_1111111_1);

    // Basic scan of 12:34 with the colon on; first cycle after release blank.
    set_time(4'd1, 4'd2, 4'd3, 4'd4);
    dp  = 1'b1;
    rst = 1'b0;
    step();
    check("first_blank", {en_a, seg_a, dp_a}, 12'b1111_1111111_1);
    step();
    check("first_digit", {en_a, seg_a, dp_a}, 12'b1110_0011001_1);
    repeat (32) step();

    // Change to 56:78 during the idx 2 slot; the frame keeps showing 12:34.
    for (int n = 0; n < 16 && pos[0] != 9; n++) step();
    set_time(4'd5, 4'd6, 4'd7, 4'd8);
    repeat (24) step();

    // Leading-zero suppression on and off for 05:00.
    set_time(4'd0, 4'd5, 4'd0, 4'd0);
    bl = 1'b1;
    repeat (32) step();
    bl = 1'b0;
    repeat (32) step();

    // Invalid BCD in tens_second shows a dash.
    ts = 4'hB;
    repeat (32) step();

    // One-cycle reset at pre = 2, idx = 2, with new inputs afterwards.
    for (int n = 0; n < 16 && pos[0] != 10; n++) step();
    rst = 1'b1;
    step();
    check("midreset_blank", {en_a, seg_a, dp_a}, 12'b1111_1111111_1);
    rst = 1'b0;
    set_time(4'd9, 4'd8, 4'd7, 4'd6);
    repeat (24) step();

    // Randomised inputs with occasional resets.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(3) == 0) begin
        us = 4'($urandom); ts = 4'($urandom);
        um = 4'($urandom); tm = 4'($urandom);
        if ($urandom_range(1) == 0) tm = 4'd0;
      end
      if ($urandom_range(7) == 0) bl = 1'($urandom);
      if ($urandom_range(7) == 0) dp = 1'($urandom);
      rst = ($urandom_range(99) == 0);
      step();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
